// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin arbiter/sequencer for a single shared combinational ALU.
// Holds operands for the op latency (MUL_LAT cycles for MUL) and returns a registered, ID-tagged result.
module alu_share_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [3:0]  req0_ctrl_i,
    input  logic [31:0] req0_src1_i,
    input  logic [31:0] req0_src2_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [3:0]  req1_ctrl_i,
    input  logic [31:0] req1_src1_i,
    input  logic [31:0] req1_src2_i,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o
);

    localparam logic [3:0] CTRL_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] alu_src1_q, alu_src1_d;
    logic [31:0] alu_src2_q, alu_src2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;

    logic        grant;
    logic        ready0;
    logic        ready1;
    logic [3:0]  sel_ctrl;

    // NOTE: every signal written here gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_src1_d   = alu_src1_q;
        alu_src2_d   = alu_src2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        // On a tie the requester that did not win last time goes first.
        grant = 1'b0;
        if (req1_valid_i && !req0_valid_i) begin
            grant = 1'b1;
        end else if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant_q;
        end

        ready0   = (state_q == IDLE) && !grant && req0_valid_i;
        ready1   = (state_q == IDLE) &&  grant && req1_valid_i;
        sel_ctrl = grant ? req1_ctrl_i : req0_ctrl_i;

        unique case (state_q)
            IDLE: begin
                if (ready0 || ready1) begin
                    alu_ctrl_d   = sel_ctrl;
                    alu_src1_d   = grant ? req1_src1_i : req0_src1_i;
                    alu_src2_d   = grant ? req1_src2_i : req0_src2_i;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = (sel_ctrl == CTRL_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = alu_result_i;
                    rsp_zero_d   = alu_zero_i;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            alu_ctrl_q   <= 4'd0;
            alu_src1_q   <= 32'd0;
            alu_src2_q   <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src1_q   <= alu_src1_d;
            alu_src2_q   <= alu_src2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign req0_ready_o = ready0;
    assign req1_ready_o = ready1;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign alu_src1_o   = alu_src1_q;
    assign alu_src2_o   = alu_src2_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;

endmodule
